// File: rtl/addsub_ctrl_pkg.sv
// Shared definitions for the add/subtract sequencing controller:
// FSM state encoding, datapath mode constants and the debounce counter sizing.
package addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_CAPT  = 2'd3
   } ctrl_state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Counter must be able to hold values 0..samples.
   function automatic int deb_cnt_w(input int samples);
      return $clog2(samples + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: accepts a new level after DEB_SAMPLES consecutive
// clken samples that differ from the current stable level; pulses on a press.
module btn_debounce
   import addsub_ctrl_pkg::*;
#(
   parameter int DEB_SAMPLES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic clken,
   input  logic raw,
   output logic pulse
);

   localparam int             CW       = deb_cnt_w(DEB_SAMPLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_SAMPLES - 1);

   logic          stable;
   logic [CW-1:0] cnt;
   logic          accept;

   // The sample that completes a run of differing samples flips the stable level.
   assign accept = clken && (raw != stable) && (cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         pulse <= accept && raw;
         if (clken) begin
            if (raw != stable) begin
               if (cnt == CNT_LAST) begin
                  stable <= raw;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Sequencing controller for the 4-bit add/subtract datapath: debounced button
// commands drive the external adder/subtractor and capture its result.
module addsub_seq_ctrl
   import addsub_ctrl_pkg::*;
#(
   parameter int DEB_SAMPLES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clken,
   input  logic        btn_load,
   input  logic        btn_add,
   input  logic        btn_sub,
   input  logic [7:0]  sw,
   output logic        as_addsub,
   output logic [3:0]  as_a,
   output logic [3:0]  as_b,
   input  logic [3:0]  as_r,
   input  logic        as_co,
   output logic [3:0]  acc,
   output logic        cflag,
   output logic        ovf,
   output logic [7:0]  opcount,
   output logic        busy,
   output logic [15:0] abus,
   output logic [1:0]  dbg_state
);

   ctrl_state_t state_q, state_d;
   logic        p_load, p_add, p_sub;
   logic [3:0]  breg;
   logic        opreg;
   logic        start_op;
   logic        op_mode;
   logic        ovf_calc;

   btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_load (
      .clock(clock), .reset(reset), .clken(clken), .raw(btn_load), .pulse(p_load)
   );
   btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_add (
      .clock(clock), .reset(reset), .clken(clken), .raw(btn_add), .pulse(p_add)
   );
   btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_sub (
      .clock(clock), .reset(reset), .clken(clken), .raw(btn_sub), .pulse(p_sub)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Commands are only looked at in IDLE, so pulses while busy are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (p_load)               state_d = ST_LOAD;
            else if (p_sub || p_add)  state_d = ST_DRIVE;
         end
         ST_LOAD:  state_d = ST_IDLE;
         ST_DRIVE: state_d = ST_CAPT;
         ST_CAPT:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      start_op = (state_q == ST_IDLE) && !p_load && (p_sub || p_add);
      op_mode  = p_sub ? MODE_SUB : MODE_ADD;
      // Subtract is A + ~B + 1, so the effective sign of B is inverted.
      ovf_calc = (as_a[3] == (breg[3] ^ opreg)) && (as_r[3] != as_a[3]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc     <= 4'd0;
         cflag   <= 1'b0;
         ovf     <= 1'b0;
         opcount <= 8'd0;
         breg    <= 4'd0;
         opreg   <= MODE_ADD;
         as_a    <= 4'd0;
      end else begin
         if (start_op) begin
            breg  <= sw[3:0];
            opreg <= op_mode;
            as_a  <= acc;
         end
         if (state_q == ST_LOAD) begin
            acc     <= sw[7:4];
            cflag   <= 1'b0;
            ovf     <= 1'b0;
            opcount <= opcount + 8'd1;
         end else if (state_q == ST_CAPT) begin
            acc     <= as_r;
            cflag   <= as_co;
            ovf     <= ovf_calc;
            opcount <= opcount + 8'd1;
         end
      end
   end

   assign as_b      = breg;
   assign as_addsub = opreg;
   assign abus      = {3'b000, cflag, acc, sw[7:4], sw[3:0]};
   assign dbg_state = state_q;

endmodule
